bus_initiator: RTL and testbench
================================

BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 255, meaning wait-state cycles tolerated before abort (range 1..255).
REQ-002 SHALL have parameter IO_AUTO_WAIT, default 1, meaning number of forced wait states in I/O cycles (0 or 1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req, input, 1, start-cycle request, sampled only in IDLE.
REQ-006 SHALL have port req_we, input, 1, 1=write, 0=read.
REQ-007 SHALL have port req_io, input, 1, 1=I/O cycle, 0=memory cycle.
REQ-008 SHALL have port req_m1, input, 1, 1=opcode fetch; ignored when req_io=1 or req_we=1.
REQ-009 SHALL have port req_addr, input, 16, cycle address.
REQ-010 SHALL have port req_wdata, input, 8, write data.
REQ-011 SHALL have port busy, output, 1, high from the cycle after acceptance until return to IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse on successful completion.
REQ-013 SHALL have port err, output, 1, one-cycle pulse on wait timeout abort.
REQ-014 SHALL have port rdata, output, 8, data captured by the last successful read.
REQ-015 SHALL have ports addr (output, 16), data (inout, 8), mreq_n, iorq_n, rd_n, wr_n, m1_n (outputs, 1, active-low Z80 strobes), and wait_n (input, 1, active-low wait).

Function
REQ-016 SHALL implement states IDLE, T1, T2, TW, T3, one clock each except TW.
REQ-017 In IDLE, SHALL drive all strobes high and data Z, hold addr at the last value, and keep busy low.
REQ-018 On req=1 in IDLE, SHALL latch all req_* fields and enter T1; req in any other state SHALL be ignored.
REQ-019 Memory read: mreq_n and rd_n SHALL be low in T1, T2, TW and T3.
REQ-020 Memory write: mreq_n SHALL be low in T1 through T3; wr_n SHALL be low in T2, TW and T3; data SHALL be driven with the latched wdata from T1 through T3.
REQ-021 I/O: iorq_n and rd_n (or wr_n) SHALL be low in T2, TW and T3 only; write data SHALL be driven from T1 through T3.
REQ-022 Opcode fetch: m1_n SHALL be low in T1, T2, TW and T3 alongside memory-read strobes; its release on T3 exit gives a rising m1_n edge.
REQ-023 From T2, SHALL go to TW if wait_n=0 or an I/O cycle has forced waits remaining, else to T3.
REQ-024 In TW, SHALL stay while wait_n=0 or forced waits remain, and SHALL increment an 8-bit wait counter that is cleared on T1.
REQ-025 If the wait counter reaches WAIT_MAX while in TW, SHALL release all strobes and data, pulse err for one cycle, leave rdata unchanged, and return to IDLE.
REQ-026 Reads SHALL capture data into rdata on the clock edge that leaves T3.
REQ-027 SHALL pulse done in the first IDLE cycle after T3; done and err SHALL never be high together.
REQ-028 Minimum cycle length SHALL be 4 clocks (T1, T2, T3, then IDLE) for memory, and 4 + IO_AUTO_WAIT clocks for I/O.

Reset
REQ-029 While reset is high, SHALL immediately force state IDLE, all strobes high, data Z, addr 0, rdata 0, busy, done and err 0, and wait counter 0, including mid-cycle.
REQ-030 The first req SHALL be sampled on the first rising clk after reset is deasserted.

Structure
REQ-031 State encoding, cycle-type constants and the default WAIT_MAX SHALL live in the shared megamapper package.
REQ-032 The wait counter and timeout compare SHALL be one sub-module, wait_timer; strobe decode SHALL be registered from the state, with no glitching combinational strobes.

Verification
REQ-033 Memory read, addr 0x1234, wait_n=1, bus data 0xA5 -> mreq_n and rd_n low for 3 clocks, rdata=0xA5, done at clock 4.
REQ-034 I/O write, addr 0x0041, wdata 0x3C, IO_AUTO_WAIT=1 -> iorq_n and wr_n low for 3 clocks (T2, TW, T3), data=0x3C for 4 clocks, done at clock 5.
REQ-035 Opcode fetch with bus data 0xED -> m1_n low for 3 clocks, rising m1_n coincides with T3 exit, rdata=0xED.
REQ-036 Memory read with wait_n held low for 300 clocks, WAIT_MAX=255 -> err pulse after 255 TW cycles, strobes released, rdata unchanged.
REQ-037 Reset asserted during TW of a memory write, plus a req pulse while busy -> strobes high and data Z immediately, no done or err, and the busy-time req is never executed.

Source files
------------

// File: rtl/megamapper_pkg.sv
// megamapper_pkg: shared state encoding, cycle types and strobe decode for the Z80-style bus initiator.
package megamapper_pkg;
    localparam int unsigned WAIT_MAX_DEFAULT = 255;
    typedef enum logic [2:0] {ST_IDLE, ST_T1, ST_T2, ST_TW, ST_T3} state_e;
    typedef enum logic [2:0] {CYC_MEM_RD, CYC_MEM_WR, CYC_IO_RD, CYC_IO_WR, CYC_M1} cyc_e;
    typedef struct packed {
        logic mreq;
        logic iorq;
        logic rd;
        logic wr;
        logic m1;
        logic oe;
    } strobe_t;
    function automatic cyc_e cyc_of(input logic we, input logic io, input logic m1);
        return io ? (we ? CYC_IO_WR : CYC_IO_RD) : we ? CYC_MEM_WR : m1 ? CYC_M1 : CYC_MEM_RD;
    endfunction
    function automatic logic is_io(input cyc_e c);
        return c == CYC_IO_RD || c == CYC_IO_WR;
    endfunction
    function automatic logic is_wr(input cyc_e c);
        return c == CYC_MEM_WR || c == CYC_IO_WR;
    endfunction
    // Asserted-high strobe set for a state; I/O strobes start one state later than memory ones.
    function automatic strobe_t decode(input state_e s, input cyc_e c);
        strobe_t st;
        logic act;
        logic late;
        act = s != ST_IDLE;
        late = act && s != ST_T1;
        st.mreq = act && !is_io(c);
        st.iorq = late && is_io(c);
        st.rd = !is_wr(c) && (is_io(c) ? late : act);
        st.wr = late && is_wr(c);
        st.m1 = act && c == CYC_M1;
        st.oe = act && is_wr(c);
        return st;
    endfunction
endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts TW cycles and flags the cycle in which the wait budget runs out.
module wait_timer #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count,
    output logic       last
);
    logic [7:0] count_d;
    logic [7:0] count_q;
    always_comb count_d = clr ? 8'd0 : inc ? count_q + 8'd1 : count_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) count_q <= 8'd0;
        else count_q <= count_d;
    assign count = count_q;
    assign last = count_q == 8'(WAIT_MAX - 1);
endmodule

// File: rtl/bus_initiator.sv
// bus_initiator: Z80-style bus cycle generator (memory, I/O, opcode fetch) with wait states and timeout abort.
module bus_initiator
    import megamapper_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT,
    parameter int unsigned IO_AUTO_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_io,
    input  logic        req_m1,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic [15:0] addr,
    inout  wire  [7:0]  data,
    output logic        mreq_n,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        m1_n,
    input  logic        wait_n
);
    state_e state_d, state_q;
    cyc_e cyc_d, cyc_q;
    strobe_t strb_d, strb_q;
    logic [15:0] addr_d, addr_q;
    logic [7:0] wdata_d, wdata_q, rdata_d, rdata_q;
    logic busy_d, busy_q, done_d, done_q, err_d, err_q;
    logic accept, forced, stay, abort, tmr_last;
    logic [7:0] tmr_count;
    wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk(clk),
        .reset(reset),
        .clr(state_q == ST_T1),
        .inc(state_q == ST_TW),
        .count(tmr_count),
        .last(tmr_last)
    );
    // Forced I/O waits are judged against the count including the TW cycle now in progress.
    always_comb begin
        accept = state_q == ST_IDLE && req;
        forced = is_io(cyc_q) && (state_q == ST_T2 ? IO_AUTO_WAIT != 0 : 32'(tmr_count) + 1 < IO_AUTO_WAIT);
        stay = !wait_n || forced;
        abort = state_q == ST_TW && stay && tmr_last;
        state_d = state_q == ST_IDLE ? (req ? ST_T1 : ST_IDLE)
                : state_q == ST_T1 ? ST_T2
                : state_q == ST_T2 ? (stay ? ST_TW : ST_T3)
                : state_q == ST_TW ? (abort ? ST_IDLE : stay ? ST_TW : ST_T3)
                : ST_IDLE;
        cyc_d = accept ? cyc_of(req_we, req_io, req_m1) : cyc_q;
        addr_d = accept ? req_addr : addr_q;
        wdata_d = accept ? req_wdata : wdata_q;
        rdata_d = state_q == ST_T3 && !is_wr(cyc_q) ? data : rdata_q;
        strb_d = decode(state_d, cyc_d);
        busy_d = state_d != ST_IDLE;
        done_d = state_q == ST_T3;
        err_d = abort;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= ST_IDLE;
            cyc_q <= CYC_MEM_RD;
            strb_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q <= cyc_d;
            strb_q <= strb_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    assign data = strb_q.oe ? wdata_q : 8'hzz;
    assign addr = addr_q;
    assign rdata = rdata_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
    assign mreq_n = !strb_q.mreq;
    assign iorq_n = !strb_q.iorq;
    assign rd_n = !strb_q.rd;
    assign wr_n = !strb_q.wr;
    assign m1_n = !strb_q.m1;
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: randomized bus cycles checked against a phase-based model of the bus protocol.
module tb_bus_initiator;
    localparam int WMAX = 255;
    localparam int AUTO = 1;
    logic clk = 0;
    logic reset = 0;
    logic req = 0, req_we = 0, req_io = 0, req_m1 = 0, wait_n = 1;
    logic [15:0] req_addr = 0;
    logic [7:0] req_wdata = 0;
    logic busy, done, err, mreq_n, iorq_n, rd_n, wr_n, m1_n;
    logic [7:0] rdata;
    logic [15:0] addr;
    wire [7:0] data;
    logic tb_drv = 0;
    logic [7:0] tb_val = 0;
    logic [7:0] model_rdata = 0;
    logic [15:0] model_addr = 0;
    int n_run = 0, n_fail = 0;
    assign data = tb_drv ? tb_val : 8'hzz;
    always #5 clk = ~clk;
    bus_initiator #(.WAIT_MAX(WMAX), .IO_AUTO_WAIT(AUTO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_io(req_io), .req_m1(req_m1),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .addr(addr), .data(data), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .wait_n(wait_n)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Cycle c counts from T1 (c=0); wait_n is held low for cycles 1..n, giving n requested wait states.
    task automatic txn(input logic we, input logic io, input logic m1, input logic [15:0] a,
                       input logic [7:0] wd, input logic [7:0] rv, input int n, input bit junk);
        bit rd = !we;
        bit mem = !io;
        bit fetch = m1 && !io && !we;
        int w = io ? (n > AUTO ? n : AUTO) : n;
        bit to = w > WMAX;
        int len = to ? 2 + WMAX : 3 + w;
        bit act, late;
        logic [7:0] exp;
        @(posedge clk); #1;
        req = 1; req_we = we; req_io = io; req_m1 = m1; req_addr = a; req_wdata = wd;
        tb_drv = rd; tb_val = rv;
        @(posedge clk); #1;
        req = 0; {req_we, req_io, req_m1} = 3'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
        model_addr = a;
        for (int c = 0; c <= len + 1; c++) begin
            wait_n = !(c >= 1 && c <= n);
            req = junk && c == 1;
            @(negedge clk);
            act = c < len;
            late = c >= 1;
            exp = {act, c == len && !to, c == len && to, !(act && mem), !(act && io && late),
                   !(act && rd && (mem || late)), !(act && we && late), !(act && fetch)};
            check($sformatf("strobes c%0d", c), {busy, done, err, mreq_n, iorq_n, rd_n, wr_n, m1_n}, exp);
            if (c == 0 || c == len) check($sformatf("addr c%0d", c), addr, model_addr);
            if (act && we) check($sformatf("wdata c%0d", c), data, wd);
            if (c == len) begin
                if (rd && !to) model_rdata = rv;
                check("rdata", rdata, model_rdata);
            end
            @(posedge clk); #1;
        end
        req = 0; tb_drv = 0; wait_n = 1;
    endtask
    logic [2:0] t;
    initial begin
        #1 reset = 1;
        #1 check("reset state", {busy, done, err, mreq_n, iorq_n, rd_n, wr_n, m1_n}, 8'b000_11111);
        check("reset addr", addr, 0);
        check("reset rdata", rdata, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        txn(0, 0, 0, 16'h1234, 8'h00, 8'hA5, 0, 0);
        txn(1, 1, 0, 16'h0041, 8'h3C, 8'h00, 0, 0);
        txn(0, 0, 1, 16'h0100, 8'h00, 8'hED, 0, 0);
        for (int i = 0; i < 40; i++) begin
            t = 3'($urandom);
            txn(t[0], t[1], t[2], 16'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
        end
        txn(0, 0, 0, 16'h2000, 8'h00, 8'h5A, 300, 0);
        txn(1, 0, 0, 16'h3000, 8'h99, 8'h00, WMAX, 0);
        @(posedge clk); #1;
        req = 1; req_we = 1; req_io = 0; req_m1 = 0; req_addr = 16'hBEEF; req_wdata = 8'h77; wait_n = 0;
        @(posedge clk); #1;
        req = 0;
        @(posedge clk); #1;
        req = 1; req_we = 0; req_addr = 16'h0BAD;
        @(posedge clk); #1;
        req = 0;
        @(posedge clk); #1;
        check("busy before reset", busy, 1);
        check("wr_n before reset", wr_n, 0);
        reset = 1;
        #1 check("reset mid-cycle", {busy, done, err, mreq_n, iorq_n, rd_n, wr_n, m1_n}, 8'b000_11111);
        check("reset mid addr", addr, 0);
        check("reset mid rdata", rdata, 0);
        model_rdata = 0; model_addr = 0;
        @(posedge clk); #1;
        reset = 0; wait_n = 1;
        repeat (6) begin
            @(negedge clk);
            check("idle after reset", {busy, done, err, mreq_n, iorq_n, rd_n, wr_n, m1_n}, 8'b000_11111);
            check("addr after reset", addr, 0);
        end
        txn(0, 1, 0, 16'h00FE, 8'h00, 8'hC3, 2, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
